// File: rtl/nand_sync_lun_target.sv
// Synchronous-interface NAND LUN target model: one data register page, read/program/erase/ID/status/reset.
// Optional NAND_LUN_FAIL_INJ_EN adds FAIL_INJ; PAGE_BYTES must be a power of two no larger than 256.
module nand_sync_lun_target #(
  parameter int          PAGE_BYTES = 16,
  parameter int          T_READ     = 8,
  parameter int          T_PROG     = 32,
  parameter int          T_ERASE    = 64,
  parameter int          T_RST      = 4,
  parameter logic [31:0] ID_WORD    = 32'h2C88_0427
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       CEN,
  input  logic       CLE,
  input  logic       ALE,
  input  logic       WRN,
  input  logic       WPN,
`ifdef NAND_LUN_FAIL_INJ_EN
  input  logic       FAIL_INJ,
`endif
  input  logic [7:0] DQ_I,
  output logic [7:0] DQ_O,
  output logic       DQ_OE,
  output logic       DQS_O,
  output logic       RB
);

  // state        | meaning
  // IDLE         | waiting for a command
  // CMD_ADDR     | command latched, collecting address cycles
  // DIN          | program data-in, writing at the pointer
  // BUSY         | array operation counting down, RB low
  // DOUT_PAGE    | data-out from the data register at the pointer
  // DOUT_STATUS  | data-out of the status byte; ret_q holds the state to resume
  // DOUT_ID      | data-out of ID_WORD bytes
  typedef enum logic [2:0] {
    S_IDLE, S_CMD_ADDR, S_DIN, S_BUSY, S_DOUT_PAGE, S_DOUT_STATUS, S_DOUT_ID
  } state_t;

  typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ERASE, OP_ID} op_t;

  localparam int PW   = $clog2(PAGE_BYTES);
  localparam int TM1  = (T_READ > T_PROG) ? T_READ : T_PROG;
  localparam int TM2  = (T_ERASE > T_RST) ? T_ERASE : T_RST;
  localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
  localparam int BW   = $clog2(TMAX + 1);

  state_t          state_q, state_d, ret_q, ret_d, tgt_q, tgt_d, eff;
  op_t             op_q, op_d;
  logic [2:0]      addr_cnt_q, addr_cnt_d;
  logic [PW-1:0]   col_q, col_d, ptr_q, ptr_d;
  logic [BW-1:0]   busy_cnt_q, busy_cnt_d;
  logic [1:0]      id_idx_q, id_idx_d;
  logic [7:0]      dq_o_q, dq_o_d;
  logic            fail_q, fail_d, wp_q, wp_d, erase_q, erase_d, inj_q, inj_d;
  logic            dqs_q, dqs_d, dq_oe_q, dq_oe_d;
  logic            busy, is_cmd, is_addr, is_din, is_dout, mem_we, mem_fill, fail_inj;
  logic [7:0]      mem_q [PAGE_BYTES];

`ifdef NAND_LUN_FAIL_INJ_EN
  assign fail_inj = FAIL_INJ;
`else
  assign fail_inj = 1'b0;
`endif

  assign busy    = (busy_cnt_q != '0);
  assign is_cmd  = !CEN &&  CLE && !ALE &&  WRN;
  assign is_addr = !CEN && !CLE &&  ALE &&  WRN;
  assign is_din  = !CEN &&  CLE &&  ALE &&  WRN;
  assign is_dout = !CEN &&  CLE &&  ALE && !WRN;
  assign eff     = (state_q == S_DOUT_STATUS) ? ret_q : state_q;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    tgt_d      = tgt_q;
    op_d       = op_q;
    addr_cnt_d = addr_cnt_q;
    col_d      = col_q;
    ptr_d      = ptr_q;
    busy_cnt_d = busy_cnt_q;
    id_idx_d   = id_idx_q;
    dq_o_d     = dq_o_q;
    fail_d     = fail_q;
    wp_d       = wp_q;
    erase_d    = erase_q;
    inj_d      = inj_q;
    dqs_d      = 1'b0;
    dq_oe_d    = !CEN && !WRN;
    mem_we     = 1'b0;
    mem_fill   = 1'b0;

    // Countdown runs regardless of CEN; completion lands in ret_q if status is being read.
    if (busy) begin
      busy_cnt_d = busy_cnt_q - BW'(1);
      if (busy_cnt_q == BW'(1)) begin
        if (state_q == S_BUSY) state_d = tgt_q;
        else if (state_q == S_DOUT_STATUS) ret_d = tgt_q;
        mem_fill = erase_q;
        erase_d  = 1'b0;
        if (inj_q) fail_d = 1'b1;
        inj_d    = 1'b0;
      end
    end

    if (is_cmd) begin
      wp_d = WPN;
      if (DQ_I == 8'hFF) begin
        busy_cnt_d = BW'(T_RST);
        tgt_d      = S_IDLE;
        state_d    = S_BUSY;
        fail_d     = 1'b0;
        ptr_d      = '0;
        erase_d    = 1'b0;
        inj_d      = 1'b0;
        mem_fill   = 1'b0;
      end else if (DQ_I == 8'h70) begin
        if (state_q != S_DOUT_STATUS) ret_d = state_d;
        state_d = S_DOUT_STATUS;
      end else if (busy) begin
        if (state_q == S_DOUT_STATUS) state_d = ret_d;
      end else begin
        state_d = S_IDLE;
        unique case (DQ_I)
          8'h00, 8'h80, 8'h60, 8'h90: begin
            state_d    = S_CMD_ADDR;
            addr_cnt_d = '0;
            if (DQ_I != 8'h90) fail_d = 1'b0;
            op_d = (DQ_I == 8'h00) ? OP_READ :
                   (DQ_I == 8'h80) ? OP_PROG :
                   (DQ_I == 8'h60) ? OP_ERASE : OP_ID;
          end
          8'h30: if (eff == S_CMD_ADDR && op_q == OP_READ && addr_cnt_q == 3'd5) begin
            state_d    = S_BUSY;
            busy_cnt_d = BW'(T_READ);
            tgt_d      = S_DOUT_PAGE;
            ptr_d      = col_q;
          end
          8'h10: if (eff == S_DIN) begin
            if (!WPN) fail_d = 1'b1;
            else begin
              state_d    = S_BUSY;
              busy_cnt_d = BW'(T_PROG);
              tgt_d      = S_IDLE;
              inj_d      = fail_inj;
            end
          end
          8'hD0: if (eff == S_CMD_ADDR && op_q == OP_ERASE && addr_cnt_q == 3'd3) begin
            if (!WPN) fail_d = 1'b1;
            else begin
              state_d    = S_BUSY;
              busy_cnt_d = BW'(T_ERASE);
              tgt_d      = S_IDLE;
              erase_d    = 1'b1;
              inj_d      = fail_inj;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (is_addr && !busy) begin
      if (state_q != S_CMD_ADDR) state_d = S_IDLE;
      else begin
        unique case (op_q)
          OP_READ, OP_PROG: begin
            if (addr_cnt_q == 3'd5) state_d = S_IDLE;
            else begin
              addr_cnt_d = addr_cnt_q + 3'd1;
              if (addr_cnt_q == 3'd0) col_d = DQ_I[PW-1:0];
              if (op_q == OP_PROG && addr_cnt_q == 3'd4) begin
                state_d = S_DIN;
                ptr_d   = col_q;
              end
            end
          end
          OP_ERASE: begin
            if (addr_cnt_q == 3'd3) state_d = S_IDLE;
            else addr_cnt_d = addr_cnt_q + 3'd1;
          end
          default: begin
            state_d  = S_DOUT_ID;
            id_idx_d = '0;
          end
        endcase
      end
    end else if (is_din && !busy) begin
      if (state_q == S_DIN) begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + PW'(1);
      end else begin
        state_d = S_IDLE;
      end
    end else if (is_dout) begin
      unique case (state_q)
        S_DOUT_PAGE: begin
          dq_o_d = mem_q[ptr_q];
          dqs_d  = 1'b1;
          ptr_d  = ptr_q + PW'(1);
        end
        S_DOUT_STATUS: begin
          dq_o_d = {wp_q, !busy, !busy, 4'b0000, fail_q};
          dqs_d  = 1'b1;
        end
        S_DOUT_ID: begin
          dq_o_d   = ID_WORD[{id_idx_q, 3'b000} +: 8];
          dqs_d    = 1'b1;
          id_idx_d = id_idx_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      tgt_q      <= S_IDLE;
      op_q       <= OP_READ;
      addr_cnt_q <= '0;
      col_q      <= '0;
      ptr_q      <= '0;
      busy_cnt_q <= '0;
      id_idx_q   <= '0;
      dq_o_q     <= 8'h00;
      fail_q     <= 1'b0;
      wp_q       <= 1'b1;
      erase_q    <= 1'b0;
      inj_q      <= 1'b0;
      dqs_q      <= 1'b0;
      dq_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      tgt_q      <= tgt_d;
      op_q       <= op_d;
      addr_cnt_q <= addr_cnt_d;
      col_q      <= col_d;
      ptr_q      <= ptr_d;
      busy_cnt_q <= busy_cnt_d;
      id_idx_q   <= id_idx_d;
      dq_o_q     <= dq_o_d;
      fail_q     <= fail_d;
      wp_q       <= wp_d;
      erase_q    <= erase_d;
      inj_q      <= inj_d;
      dqs_q      <= dqs_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  // Data register has no reset; contents after reset are don't-care.
  always_ff @(posedge CLK) begin
    if (mem_fill) begin
      for (int i = 0; i < PAGE_BYTES; i++) mem_q[i] <= 8'hFF;
    end else if (mem_we) begin
      mem_q[ptr_q] <= DQ_I;
    end
  end

  assign DQ_O  = dq_o_q;
  assign DQS_O = dqs_q;
  assign DQ_OE = dq_oe_q;
  assign RB    = !busy;

endmodule

// File: tb/tb_nand_sync_lun_target.sv
// Directed bench for nand_sync_lun_target: vector table for status/ID/write-protect, hand sequences for busy timing.
module tb_nand_sync_lun_target;

  localparam logic [2:0] T_IDLE = 3'd0, T_CMD = 3'd1, T_ADDR = 3'd2, T_DIN = 3'd3, T_DOUT = 3'd4;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       CEN = 1'b1, CLE = 1'b0, ALE = 1'b0, WRN = 1'b1, WPN = 1'b1;
  logic [7:0] DQ_I = 8'h00;
  logic [7:0] DQ_O;
  logic       DQ_OE, DQS_O, RB;

  int checks = 0;
  int errors = 0;

  nand_sync_lun_target dut (
    .CLK(CLK), .RESETN(RESETN), .CEN(CEN), .CLE(CLE), .ALE(ALE), .WRN(WRN), .WPN(WPN),
`ifdef NAND_LUN_FAIL_INJ_EN
    .FAIL_INJ(1'b0),
`endif
    .DQ_I(DQ_I), .DQ_O(DQ_O), .DQ_OE(DQ_OE), .DQS_O(DQS_O), .RB(RB)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] ty;
    logic       wpn;
    logic [7:0] dq;
    logic       chk;
    logic [7:0] edq;
    logic       edqs;
    logic       eoe;
    logic       erb;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [2:0] ty, input logic [7:0] dq, input logic wpn,
                              input logic chk, input logic [7:0] edq, input logic edqs,
                              input logic eoe, input logic erb);
    vec_t v;
    v.ty = ty; v.dq = dq; v.wpn = wpn; v.chk = chk;
    v.edq = edq; v.edqs = edqs; v.eoe = eoe; v.erb = erb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] ty, input logic [7:0] dq, input logic wpn = 1'b1);
    @(negedge CLK);
    WPN  = wpn;
    DQ_I = dq;
    CEN  = (ty == T_IDLE);
    CLE  = (ty == T_CMD) || (ty == T_DIN) || (ty == T_DOUT);
    ALE  = (ty == T_ADDR) || (ty == T_DIN) || (ty == T_DOUT);
    WRN  = (ty != T_DOUT);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (RB === 1'b0 && n < 300) begin
      cyc(T_IDLE, 8'h00);
      n++;
    end
  endtask

  task automatic addr5(input logic [7:0] col);
    cyc(T_ADDR, col);
    for (int i = 0; i < 4; i++) cyc(T_ADDR, 8'h00);
  endtask

  task automatic dout_chk(input string name, input logic [7:0] exp);
    cyc(T_DOUT, 8'h00);
    check(name, {DQ_O, DQS_O, DQ_OE}, {exp, 1'b1, 1'b1});
  endtask

  initial begin
    int n;
    vecs[0]  = mk(T_CMD,  8'h70, 1, 0, 8'h00, 0, 0, 1);
    vecs[1]  = mk(T_DOUT, 8'h00, 1, 1, 8'hE0, 1, 1, 1);
    vecs[2]  = mk(T_IDLE, 8'h00, 1, 1, 8'hE0, 0, 0, 1);
    vecs[3]  = mk(T_CMD,  8'h90, 1, 0, 8'h00, 0, 0, 1);
    vecs[4]  = mk(T_ADDR, 8'h00, 1, 0, 8'h00, 0, 0, 1);
    vecs[5]  = mk(T_DOUT, 8'h00, 1, 1, 8'h27, 1, 1, 1);
    vecs[6]  = mk(T_DOUT, 8'h00, 1, 1, 8'h04, 1, 1, 1);
    vecs[7]  = mk(T_DOUT, 8'h00, 1, 1, 8'h88, 1, 1, 1);
    vecs[8]  = mk(T_DOUT, 8'h00, 1, 1, 8'h2C, 1, 1, 1);
    vecs[9]  = mk(T_DOUT, 8'h00, 1, 1, 8'h27, 1, 1, 1);
    vecs[10] = mk(T_CMD,  8'h60, 0, 0, 8'h00, 0, 0, 1);
    vecs[11] = mk(T_ADDR, 8'h01, 0, 0, 8'h00, 0, 0, 1);
    vecs[12] = mk(T_ADDR, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    vecs[13] = mk(T_ADDR, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    vecs[14] = mk(T_CMD,  8'hD0, 0, 1, 8'h27, 0, 0, 1);
    vecs[15] = mk(T_CMD,  8'h70, 0, 0, 8'h00, 0, 0, 1);
    vecs[16] = mk(T_DOUT, 8'h00, 0, 1, 8'h61, 1, 1, 1);

    #3;
    check("reset_outputs", {DQ_O, DQS_O, DQ_OE, RB}, {8'h00, 1'b0, 1'b0, 1'b1});
    #14 RESETN = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].ty, vecs[i].dq, vecs[i].wpn);
      if (vecs[i].chk)
        check($sformatf("vec%0d", i), {DQ_O, DQS_O, DQ_OE, RB},
              {vecs[i].edq, vecs[i].edqs, vecs[i].eoe, vecs[i].erb});
    end

    // Program 00h..0Fh at column 0, then read from column 4.
    cyc(T_CMD, 8'h80);
    addr5(8'h00);
    for (int i = 0; i < 16; i++) cyc(T_DIN, 8'(i));
    cyc(T_CMD, 8'h10);
    check("prog_rb_fall", RB, 1'b0);
    wait_ready(n);
    check("prog_busy_len", n, 32);

    cyc(T_CMD, 8'h00);
    addr5(8'h04);
    cyc(T_CMD, 8'h30);
    check("read_rb_fall", RB, 1'b0);
    wait_ready(n);
    check("read_busy_len", n, 8);
    dout_chk("page_b4", 8'h04);
    dout_chk("page_b5", 8'h05);
    dout_chk("page_b6", 8'h06);

    // Erase aborted by reset command, with a status read while busy.
    cyc(T_CMD, 8'h60);
    for (int i = 0; i < 3; i++) cyc(T_ADDR, 8'h00);
    cyc(T_CMD, 8'hD0);
    check("erase_rb_fall", RB, 1'b0);
    for (int i = 0; i < 8; i++) cyc(T_IDLE, 8'h00);
    cyc(T_CMD, 8'h70);
    dout_chk("status_busy", 8'h80);
    check("erase_still_busy", RB, 1'b0);
    cyc(T_CMD, 8'hFF);
    check("rst_rb_low", RB, 1'b0);
    wait_ready(n);
    check("rst_busy_len", n, 4);
    cyc(T_CMD, 8'h70);
    dout_chk("status_after_rst", 8'hE0);

    cyc(T_CMD, 8'h00);
    addr5(8'h00);
    cyc(T_CMD, 8'h30);
    wait_ready(n);
    check("read2_busy_len", n, 8);
    dout_chk("page_kept_after_abort", 8'h00);

    // Full erase fills the register with FFh.
    cyc(T_CMD, 8'h60);
    for (int i = 0; i < 3; i++) cyc(T_ADDR, 8'h00);
    cyc(T_CMD, 8'hD0);
    wait_ready(n);
    check("erase_busy_len", n, 64);
    cyc(T_CMD, 8'h00);
    addr5(8'h0E);
    cyc(T_CMD, 8'h30);
    wait_ready(n);
    dout_chk("erased_b14", 8'hFF);
    dout_chk("erased_b15", 8'hFF);

    // Asynchronous reset in the middle of data-out.
    #2 RESETN = 1'b0;
    #1;
    check("async_reset", {DQ_O, DQS_O, DQ_OE, RB}, {8'h00, 1'b0, 1'b0, 1'b1});
    @(negedge CLK);
    RESETN = 1'b1;
    cyc(T_IDLE, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/nand_sync_lun_target.md
NAND_SYNC_LUN_TARGET -- requirements
Module: nand_sync_lun_target

Interface
REQ-001 Parameters (name, default, meaning), one per line: PAGE_BYTES, 16, data register size in bytes (power of two).
REQ-002 T_READ, 8, busy cycles after 00h/30h.
REQ-003 T_PROG, 32, busy cycles after 80h/10h.
REQ-004 T_ERASE, 64, busy cycles after 60h/D0h.
REQ-005 T_RST, 4, busy cycles after FFh.
REQ-006 ID_WORD, 32'h2C88_0427, Read ID bytes, LSB first.
REQ-007 Ports (name, direction, width, meaning), one per line: CLK  in  1  target clock (SSD_CLK from controller).
REQ-008 RESETN  in  1  reset, asynchronous, active-low.
REQ-009 CEN  in  1  chip enable, active-low.
REQ-010 CLE  in  1  command latch enable.
REQ-011 ALE  in  1  address latch enable.
REQ-012 WRN  in  1  W/R#: 1 = host writes, 0 = target drives DQ.
REQ-013 WPN  in  1  write protect, active-low.
REQ-014 DQ_I  in  8  DQ input byte.
REQ-015 DQ_O  out  8  DQ output byte.
REQ-016 DQ_OE  out  1  DQ output enable.
REQ-017 DQS_O  out  1  data strobe, one-cycle high pulse per valid output byte.
REQ-018 RB  out  1  ready/busy: 1 = ready, 0 = busy.

Function
REQ-019 Inputs are sampled on rising CLK only while CEN=0; cycle types: CLE=1,ALE=0,WRN=1 = command; CLE=0,ALE=1,WRN=1 = address; CLE=1,ALE=1,WRN=1 = data-in; CLE=1,ALE=1,WRN=0 = data-out; any other combination is idle.
REQ-020 States: IDLE, CMD_ADDR, DIN, BUSY, DOUT_PAGE, DOUT_STATUS, DOUT_ID.
REQ-021 00h enters CMD_ADDR; exactly 5 address cycles (2 column, 3 row); 30h then enters BUSY for T_READ cycles, then DOUT_PAGE with pointer = column mod PAGE_BYTES.
REQ-022 80h enters CMD_ADDR; after 5 address cycles, enters DIN; each data-in cycle writes DQ_I at the pointer and increments it (wraps at PAGE_BYTES); 10h enters BUSY for T_PROG.
REQ-023 60h takes 3 row address cycles; D0h enters BUSY for T_ERASE and fills the data register with FFh.
REQ-024 90h plus one address cycle (any value) enters DOUT_ID; successive data-out cycles return ID_WORD bytes 0..3, then repeat.
REQ-025 70h enters DOUT_STATUS; status = {WP_N_latched, RDY, RDY, 4'b0, FAIL}; legal in any state including BUSY, returning to the prior state on the next command.
REQ-026 Data-out latency: byte is on DQ_O with DQS_O=1 exactly one cycle after the sampling edge; DQ_OE is registered, high one cycle after CEN=0 and WRN=0, low one cycle after either deasserts.
REQ-027 DOUT_PAGE pointer increments per data-out cycle and wraps at PAGE_BYTES.
REQ-028 RB falls on the edge that latches the confirm command and rises after exactly the programmed cycle count.
REQ-029 While BUSY, commands other than 70h and FFh are ignored; FFh aborts: data register unchanged, BUSY restarts with T_RST.
REQ-030 FFh in any state enters BUSY for T_RST, clears FAIL and pointer, then IDLE.
REQ-031 WPN=0 at 10h or D0h: no busy, data register unchanged, FAIL=1, state IDLE.
REQ-032 Unknown command or wrong cycle type in sequence: return to IDLE, no state change; FAIL cleared by the next valid 80h/60h/00h.
REQ-033 CEN=1 does not disturb BUSY countdown.

Reset
REQ-034 RESETN=0 asynchronously forces: state IDLE, RB=1, DQ_OE=0, DQS_O=0, DQ_O=00h, FAIL=0, pointer=0, busy counter=0; data register contents are unspecified.

Configuration
REQ-035 Macro NAND_LUN_FAIL_INJ_EN: when defined, adds input FAIL_INJ (1 bit); FAIL_INJ=1 at the 10h/D0h edge sets FAIL=1 after normal busy; when undefined, the port is absent and FAIL is set only per REQ-031.

Verification
REQ-036 Reset release, 70h, one data-out cycle -> DQ_O=E0h, DQS_O pulse, RB=1.
REQ-037 80h, 5 addr (col=0), data 00h..0Fh, 10h -> RB low 32 cycles; then 00h, 5 addr (col=4), 30h -> RB low 8 cycles; 3 data-out cycles -> 04h,05h,06h.
REQ-038 90h, addr 00h, 5 data-out cycles -> 27h,04h,88h,2Ch,27h.
REQ-039 WPN=0, 60h, 3 addr, D0h -> RB stays 1; 70h read -> 61h (WP_N=0, RDY, FAIL).
REQ-040 60h, 3 addr, D0h, FFh after 10 busy cycles -> RB low until 4 cycles after FFh; 70h -> E0h.
REQ-041 Assert RESETN=0 mid-DOUT_PAGE -> DQ_OE and DQS_O low immediately, RB=1, no clock required.
